// File: rtl/turn_signal_pkg.sv
// Shared mode encodings, request decode and parameter legality check for the
// tail-light sequencer.
package turn_signal_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'b00,
    MODE_LEFT   = 2'b01,
    MODE_RIGHT  = 2'b10,
    MODE_HAZARD = 2'b11
  } mode_t;

  // Both turn switches at once is treated as a hazard request.
  function automatic mode_t decode_request(input logic left, input logic right,
                                           input logic hazard);
    mode_t m;
    if (hazard || (left && right)) m = MODE_HAZARD;
    else if (left)                 m = MODE_LEFT;
    else if (right)                m = MODE_RIGHT;
    else                           m = MODE_IDLE;
    return m;
  endfunction

  function automatic bit params_legal(input int lamps, input int tick_div,
                                      input int hold_off);
    return (lamps >= 1) && (tick_div >= 1) && (hold_off >= 0);
  endfunction

endpackage

// File: rtl/turn_signal_sequencer_prescaler.sv
// Step-rate prescaler: tick is high on the last cycle of each TICK_DIV period
// while enabled; the count is held at zero when disabled.
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  if (TICK_DIV < 1) begin : g_bad_div
    $error("tick_prescaler: TICK_DIV must be >= 1");
  end

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                count <= '0;
    else if (!enable || tick) count <= '0;
    else                      count <= count + 1'b1;
  end

endmodule

// File: rtl/turn_signal_sequencer.sv
// Tail-light sequencer: left/right sweeps, hazard flash and brake overlay,
// with all outputs registered.
module turn_signal_sequencer
  import turn_signal_pkg::*;
#(
  parameter int LAMPS    = 3,
  parameter int TICK_DIV = 4,
  parameter int HOLD_OFF = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               left,
  input  logic               right,
  input  logic               hazard,
  input  logic               brake,
  output logic [2*LAMPS-1:0] lights,
  output logic [1:0]         mode,
  output logic               step_tick
);

  localparam int SW = $clog2(LAMPS + HOLD_OFF + 1);
  localparam logic [SW-1:0] STEP_FIRST = SW'(1);
  localparam logic [SW-1:0] STEP_LAMPS = SW'(LAMPS);
  localparam logic [SW-1:0] STEP_LAST  = SW'(LAMPS + HOLD_OFF);

  if (!params_legal(LAMPS, TICK_DIV, HOLD_OFF)) begin : g_bad_params
    $error("turn_signal_sequencer: illegal LAMPS/TICK_DIV/HOLD_OFF");
  end

  mode_t               state, state_n, req;
  logic [SW-1:0]       step, step_n;
  logic                phase, phase_n;
  logic                tick;
  logic [LAMPS-1:0]    lside, rside;
  logic [2*LAMPS-1:0]  lights_n;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (state != MODE_IDLE),
    .tick   (tick)
  );

  assign req = decode_request(left, right, hazard);

  always_comb begin
    state_n = state;
    step_n  = step;
    phase_n = phase;
    if (state == MODE_IDLE) begin
      if (req != MODE_IDLE) begin
        state_n = req;
        step_n  = STEP_FIRST;
        phase_n = 1'b1;
      end
    end else if (tick) begin
      if (req != state) begin
        state_n = req;
        step_n  = (req == MODE_IDLE) ? '0 : STEP_FIRST;
        phase_n = 1'b1;
      end else begin
        step_n  = (step == STEP_LAST) ? STEP_FIRST : step + 1'b1;
        phase_n = ~phase;
      end
    end
  end

  // Lamp pattern is derived from the next state so it lands on the same edge.
  always_comb begin
    lside = '0;
    rside = '0;
    unique case (state_n)
      MODE_IDLE: begin
        lside = {LAMPS{brake}};
        rside = {LAMPS{brake}};
      end
      MODE_LEFT: begin
        for (int unsigned i = 0; i < LAMPS; i++)
          lside[i] = (step_n <= STEP_LAMPS) && (i < 32'(step_n));
        rside = {LAMPS{brake}};
      end
      MODE_RIGHT: begin
        for (int unsigned i = 0; i < LAMPS; i++)
          rside[LAMPS-1-i] = (step_n <= STEP_LAMPS) && (i < 32'(step_n));
        lside = {LAMPS{brake}};
      end
      MODE_HAZARD: begin
        lside = {LAMPS{phase_n || brake}};
        rside = {LAMPS{phase_n || brake}};
      end
    endcase
    lights_n = {lside, rside};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= MODE_IDLE;
      step      <= '0;
      phase     <= 1'b1;
      lights    <= '0;
      step_tick <= 1'b0;
    end else begin
      state     <= state_n;
      step      <= step_n;
      phase     <= phase_n;
      lights    <= lights_n;
      step_tick <= tick;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_turn_signal_sequencer.sv
// Scoreboard bench for turn_signal_sequencer against a time-based reference model.
module tb_turn_signal_sequencer;

  localparam int LAMPS    = 3;
  localparam int TICK_DIV = 4;
  localparam int HOLD_OFF = 1;

  logic clk = 1'b0;
  logic reset, left, right, hazard, brake;
  logic [2*LAMPS-1:0] lights;
  logic [1:0] mode;
  logic step_tick;

  turn_signal_sequencer #(.LAMPS(LAMPS), .TICK_DIV(TICK_DIV), .HOLD_OFF(HOLD_OFF)) dut (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
    .brake(brake), .lights(lights), .mode(mode), .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2*LAMPS-1:0] lights;
    logic [1:0]         mode;
    logic               tick;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: mode plus cycles elapsed since that mode was entered.
  int m_mode = 0;
  int m_t    = 0;

  bit fx_l, fx_r, fx_h, fx_b;
  int seg = 0;
  bit r_l, r_r, r_h, r_b;

  function automatic logic [2*LAMPS-1:0] exp_lights(input int md, input int t, input bit b);
    logic [31:0] full, lft, rgt;
    int s;
    bit on;
    full = (32'd1 << LAMPS) - 32'd1;
    lft = '0;
    rgt = '0;
    s  = (t / TICK_DIV) % (LAMPS + HOLD_OFF) + 1;
    on = ((t / TICK_DIV) % 2) == 0;
    case (md)
      0: if (b) begin lft = full; rgt = full; end
      1: begin
        if (s <= LAMPS) lft = (32'd1 << s) - 32'd1;
        if (b) rgt = full;
      end
      2: begin
        if (s <= LAMPS) rgt = full ^ ((32'd1 << (LAMPS - s)) - 32'd1);
        if (b) lft = full;
      end
      default: if (on || b) begin lft = full; rgt = full; end
    endcase
    return {lft[LAMPS-1:0], rgt[LAMPS-1:0]};
  endfunction

  task automatic model_edge(input bit l, input bit r, input bit h, input bit b, output exp_t e);
    int req;
    bit tk;
    req = (h || (l && r)) ? 3 : l ? 1 : r ? 2 : 0;
    tk = 1'b0;
    if (m_mode == 0) begin
      if (req != 0) begin m_mode = req; m_t = 0; end
    end else begin
      m_t++;
      if (m_t % TICK_DIV == 0) begin
        tk = 1'b1;
        if (req != m_mode) begin m_mode = req; m_t = 0; end
      end
    end
    e.tick   = tk;
    e.mode   = 2'(m_mode);
    e.lights = exp_lights(m_mode, m_t, b);
  endtask

  task automatic drive(input int n, input bit rnd);
    exp_t e;
    int pat;
    repeat (n) begin
      @(negedge clk);
      if (rnd) begin
        if (seg == 0) begin
          pat = $urandom_range(0, 7);
          r_l = (pat == 1) || (pat == 2) || (pat == 6) || (pat == 7);
          r_r = (pat == 3) || (pat == 4) || (pat == 6);
          r_h = (pat == 5) || (pat == 7);
          seg = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
        end
        seg--;
        if ($urandom_range(0, 7) == 0) r_b = !r_b;
        left = r_l; right = r_r; hazard = r_h; brake = r_b;
      end else begin
        left = fx_l; right = fx_r; hazard = fx_h; brake = fx_b;
      end
      model_edge(left, right, hazard, brake, e);
      sb.push_back(e);
    end
  endtask

  task automatic monitor(input int n);
    exp_t e;
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard cycle %0d: got empty queue, expected an entry", cyc);
      end else begin
        e = sb.pop_front();
        if (lights !== e.lights) begin
          errors++;
          $display("FAIL lights cycle %0d: got %b, expected %b", cyc, lights, e.lights);
        end
        checks++;
        if (mode !== e.mode) begin
          errors++;
          $display("FAIL mode cycle %0d: got %b, expected %b", cyc, mode, e.mode);
        end
        checks++;
        if (step_tick !== e.tick) begin
          errors++;
          $display("FAIL step_tick cycle %0d: got %b, expected %b", cyc, step_tick, e.tick);
        end
      end
    end
  endtask

  task automatic run_phase(input int n, input bit rnd, input bit l, input bit r,
                           input bit h, input bit b);
    fx_l = l; fx_r = r; fx_h = h; fx_b = b;
    fork
      drive(n, rnd);
      monitor(n);
    join
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (lights !== '0 || mode !== 2'b00 || step_tick !== 1'b0) begin
      errors++;
      $display("FAIL %s: got lights=%b mode=%b tick=%b, expected all zero",
               tag, lights, mode, step_tick);
    end
  endtask

  initial begin
    reset = 1'b1; left = 1'b0; right = 1'b0; hazard = 1'b0; brake = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    reset = 1'b0;

    run_phase(20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);  // left sweep from idle
    run_phase(8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_phase(20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);  // right sweep
    run_phase(8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_phase(20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);  // both turns = hazard
    run_phase(12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);  // hazard with brake
    run_phase(8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);  // brake in idle
    run_phase(20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);  // brake during left sweep
    run_phase(8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_phase(1500, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges in the middle of a left sweep.
    run_phase(10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    m_mode = 0;
    m_t = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_phase(10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    run_phase(500, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/turn_signal_sequencer.md
Name: turn_signal_sequencer

Overview:
- Parametrised tail-light sequencer driving LAMPS lamps per side.
- Adds several behaviours to the fixed 3+3 left/right sweep:
  - prescaled step rate,
  - configurable blank hold-off between sweeps,
  - hazard flash mode,
  - brake overlay.
- Sits between debounced driver switch inputs and the lamp driver pins. All outputs are registered.

Parameters:
- LAMPS, 3: lamps per side; must be >= 1.
- TICK_DIV, 4: clock cycles per sequence step; must be >= 1. A value of 1 steps every cycle.
- HOLD_OFF, 1: all-off steps after a full sweep before it restarts; must be >= 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- left  in  1  left turn request, level.
- right  in  1  right turn request, level.
- hazard  in  1  hazard request, level.
- brake  in  1  brake pedal, level.
- lights  out  2*LAMPS  lamp drives, 1 = on.
  - [2*LAMPS-1:LAMPS] is the left side; bit LAMPS is innermost, bit 2*LAMPS-1 is outermost.
  - [LAMPS-1:0] is the right side; bit LAMPS-1 is innermost, bit 0 is outermost.
- mode  out  2  current mode: 00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZARD.
- step_tick  out  1  one-cycle pulse on each sequence step (debug/verification).

Behaviour:
- Reset (asynchronous, any time, including mid-sweep): mode=00, lights=0, step_tick=0, prescaler=0, step=0, hazard phase=on. Outputs go to zero immediately, without waiting for an edge.
- Request decode, in priority order:
  - hazard=1 or (left=1 and right=1) -> HAZARD
  - else left -> LEFT
  - else right -> RIGHT
  - else -> IDLE
- Prescaler:
  - Counts 0..TICK_DIV-1 while mode != IDLE. The tick is true when count = TICK_DIV-1; the count then wraps to 0.
  - Held at 0 in IDLE.
  - step_tick is the registered tick.
- Mode state machine (IDLE, LEFT, RIGHT, HAZARD):
  - IDLE, on the first edge where a non-IDLE request is sampled: enter the requested mode with step=1 (or phase=on for HAZARD) and prescaler=0. There is no wait for a tick.
  - Non-IDLE, on a tick:
    - If the decoded request differs from the current mode, switch to it: restart at step=1 / phase=on, or go to IDLE with lights off.
    - Otherwise advance the step (or phase).
  - Non-IDLE, between ticks: request changes are ignored, with no effect until the next tick.
- Sweep (LEFT/RIGHT):
  - step runs 1..LAMPS+HOLD_OFF, then wraps to 1.
  - For step s <= LAMPS: the s innermost lamps of the active side are lit, growing outward.
  - For s > LAMPS: the active side is dark.
  - The inactive side is dark unless braking.
  - Full sweep period = (LAMPS+HOLD_OFF)*TICK_DIV cycles.
  - step register width = $clog2(LAMPS+HOLD_OFF+1).
- HAZARD: phase toggles on every tick. phase on = all 2*LAMPS lamps lit; phase off = all dark.
- Brake overlay, applied to the sampled brake value:
  - IDLE: both sides solid on.
  - LEFT: right side solid on.
  - RIGHT: left side solid on.
  - HAZARD: the off phase is forced fully on, so all lamps stay lit.
  - The turning side never shows brake.
- Output latency:
  - lights and mode are computed from the next state and the current inputs, and registered on the same edge as the state update.
  - A request or brake change sampled at edge k is visible after edge k (IDLE start; brake at any time).
  - In non-IDLE modes a request change takes effect at the first tick edge.
- Simultaneous events:
  - A brake change and a tick on the same edge are both reflected after that edge.
  - A mode switch on a tick restarts the prescaler count from 0 of the new period. The wrap already gives 0, so no extra cycle is added.

Decomposition:
- Shared package turn_signal_pkg holds:
  - mode encodings MODE_IDLE/LEFT/RIGHT/HAZARD (2-bit),
  - the request-decode function,
  - the parameter legality checks (elaboration asserts).
- One sub-module, tick_prescaler:
  - parameter TICK_DIV; ports clk, reset, enable, tick.
  - Clears the count when enable=0.

Test Plan (LAMPS=3, TICK_DIV=4, HOLD_OFF=1):
1. Reset, then left=1 sampled at edge 0 -> mode=01 and lights=001000 after edge 0. lights=011000 after edge 4, 111000 after edge 8, 000000 after edge 12, 001000 after edge 16. step_tick pulses every 4 cycles.
2. right=1 held from idle -> lights 000100, 000110, 000111, 000000, 000100 at 4-cycle spacing; mode=10.
3. left=1 and right=1 together (or hazard=1) from idle -> mode=11; lights=111111 for 4 cycles, 000000 for 4 cycles, repeating. Adding brake=1 holds 111111 continuously.
4. brake=1 in IDLE -> lights=111111 one edge later. brake=1 during a LEFT sweep -> 001111, 011111, 111111, 000111; releasing brake clears bits [2:0] after the next edge.
5. Switch mid-sweep:
   - At lights=011000, drop left and raise right 1 cycle after a tick -> lights hold 011000 until the next tick edge, then 000100 with mode=10.
   - Drop all requests -> at the next tick edge, 000000 with mode=00.
6. Assert reset asynchronously mid-sweep (between edges) -> lights=000000 and mode=00 immediately. After release with left still high -> the sweep restarts at 001000 on the first edge.
